// File: rtl/div_issue_pkg.sv
// Shared definitions for the divide-request controller: op encodings, FSM states and
// the divider timing constants the controller and its bench agree on.
package div_issue_pkg;

   localparam logic [1:0] OP_DIV_W  = 2'b00;
   localparam logic [1:0] OP_MOD_W  = 2'b01;
   localparam logic [1:0] OP_DIV_WU = 2'b10;
   localparam logic [1:0] OP_MOD_WU = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   // Cycles the divider keeps `div` high before `complete`, and accept-to-valid latency.
   localparam int unsigned DIV_ITER_CYCLES   = 34;
   localparam int unsigned DIV_ISSUE_LATENCY = 35;

endpackage

// File: rtl/div_issue.sv
// Divide-request controller: issues DIV/MOD micro-ops to the iterative divider, buffers the
// result for writeback and cancels on flush. Optional macro: DIV_ZERO_FAST_EN.
module div_issue
   import div_issue_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_src1,
   input  logic [31:0] in_src2,
   input  logic [4:0]  in_dest,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_dest,
   output logic        dv_req,
   output logic        dv_signed,
   output logic [31:0] dv_x,
   output logic [31:0] dv_y,
   input  logic        dv_complete,
   input  logic [31:0] dv_q,
   input  logic [31:0] dv_r
);

   state_e      state_q, state_d;
   logic [31:0] dv_x_q, dv_x_d;
   logic [31:0] dv_y_q, dv_y_d;
   logic        dv_signed_q, dv_signed_d;
   logic        sel_r_q, sel_r_d;
   logic [4:0]  dest_q, dest_d;
   logic [31:0] result_q, result_d;
   logic        accept;
   logic        fast_zero;

   always_comb begin
      in_ready = ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready)) & ~flush;
      accept   = in_valid & in_ready;
`ifdef DIV_ZERO_FAST_EN
      fast_zero = (in_src2 == 32'h0);
`else
      fast_zero = 1'b0;
`endif
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; flush overrides everything, including a same-cycle completion
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) state_d = fast_zero ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
               if (dv_complete) state_d = S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  if (accept) state_d = fast_zero ? S_DONE : S_BUSY;
                  else        state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs; `div` must fall in DONE so the divider's counter restarts for the next op
   always_comb begin
      dv_req     = (state_q == S_BUSY);
      out_valid  = (state_q == S_DONE);
      dv_x       = dv_x_q;
      dv_y       = dv_y_q;
      dv_signed  = dv_signed_q;
      out_result = result_q;
      out_dest   = dest_q;
   end

   always_comb begin
      dv_x_d      = dv_x_q;
      dv_y_d      = dv_y_q;
      dv_signed_d = dv_signed_q;
      sel_r_d     = sel_r_q;
      dest_d      = dest_q;
      result_d    = result_q;
      if (accept) begin
         dv_x_d      = in_src1;
         dv_y_d      = in_src2;
         dv_signed_d = ~in_op[1];
         sel_r_d     = in_op[0];
         dest_d      = in_dest;
         if (fast_zero) result_d = in_op[0] ? in_src1 : 32'hFFFF_FFFF;
      end
      if ((state_q == S_BUSY) && dv_complete && !flush) begin
         result_d = sel_r_q ? dv_r : dv_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dv_x_q      <= 32'h0;
         dv_y_q      <= 32'h0;
         dv_signed_q <= 1'b0;
         sel_r_q     <= 1'b0;
         dest_q      <= 5'h0;
         result_q    <= 32'h0;
      end else begin
         dv_x_q      <= dv_x_d;
         dv_y_q      <= dv_y_d;
         dv_signed_q <= dv_signed_d;
         sel_r_q     <= sel_r_d;
         dest_q      <= dest_d;
         result_q    <= result_d;
      end
   end

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: behavioural divider alongside the DUT, directed and random ops
// checked against an arithmetic reference model. Honours DIV_ZERO_FAST_EN.
module tb_div_issue;
   import div_issue_pkg::*;

`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk, reset;
   logic        in_valid, in_ready, flush;
   logic [1:0]  in_op;
   logic [31:0] in_src1, in_src2;
   logic [4:0]  in_dest;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_dest;
   logic        dv_req, dv_signed, dv_complete;
   logic [31:0] dv_x, dv_y, dv_q, dv_r;

   int checks = 0;
   int errors = 0;

   div_issue dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_dest    (in_dest),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_dest   (out_dest),
      .dv_req     (dv_req),
      .dv_signed  (dv_signed),
      .dv_x       (dv_x),
      .dv_y       (dv_y),
      .dv_complete(dv_complete),
      .dv_q       (dv_q),
      .dv_r       (dv_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider stand-in: counts while `div` is high, completes on the 34th cycle
   logic [5:0] dv_cnt;
   logic       spur;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        dv_cnt <= 6'd0;
      else if (!dv_req) dv_cnt <= 6'd0;
      else              dv_cnt <= dv_cnt + 6'd1;
   end
   assign dv_complete = (dv_req && (dv_cnt == 6'(DIV_ITER_CYCLES - 1))) || spur;

   // Magnitude divide plus sign fix-up, the way a real iterative divider works
   function automatic logic [63:0] div_model(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
      logic xn, yn;
      logic [31:0] ax, ay, uq, ur, q, r;
      xn = sgn & x[31];
      yn = sgn & y[31];
      ax = xn ? -x : x;
      ay = yn ? -y : y;
      if (ay == 32'h0) begin
         uq = 32'hFFFF_FFFF;
         ur = ax;
      end else begin
         uq = ax / ay;
         ur = ax % ay;
      end
      q = ((ay != 32'h0) && (xn ^ yn)) ? -uq : uq;
      r = xn ? -ur : ur;
      return {q, r};
   endfunction

   always_comb {dv_q, dv_r} = div_model(dv_x, dv_y, dv_signed);

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      case (op)
         OP_DIV_W:  return (b == 32'h0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         OP_MOD_W:  return (b == 32'h0) ? a : 32'(sa % sb);
         OP_DIV_WU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         default:   return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [31:0] b);
      return (FAST && (b == 32'h0)) ? 1 : int'(DIV_ISSUE_LATENCY);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer an op from IDLE; returns at the start of cycle T+1
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_dest = d;
      @(negedge clk);
      chk("issue_in_ready", 32'(in_ready), 32'd1);
      chk("issue_dv_req", 32'(dv_req), 32'd0);
      chk("issue_out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
   endtask

   // Starting at T+1, watch until out_valid and check timing, operands and result
   task automatic wait_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] d);
      int el, ereq, nreq, first, last, lat;
      bit hold_ok;
      el = exp_lat(b);
      ereq = (el == int'(DIV_ISSUE_LATENCY)) ? int'(DIV_ITER_CYCLES) : 0;
      nreq = 0; first = 0; last = 0; lat = 0; hold_ok = 1'b1;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (dv_req) begin
            nreq++;
            if (first == 0) first = i;
            last = i;
            if (dv_x !== a || dv_y !== b || dv_signed !== ~op[1]) hold_ok = 1'b0;
         end
         if (out_valid) begin
            lat = i;
            break;
         end
         tick();
      end
      chk("latency", 32'(lat), 32'(el));
      chk("req_cycles", 32'(nreq), 32'(ereq));
      chk("req_first", 32'(first), (ereq != 0) ? 32'd1 : 32'd0);
      chk("req_last", 32'(last), 32'(ereq));
      chk("operand_hold", 32'(hold_ok), 32'd1);
      chk("result", out_result, ref_result(op, a, b));
      chk("dest", 32'(out_dest), 32'(d));
      chk("done_in_ready", 32'(in_ready), 32'd0);
      tick();
   endtask

   // Keep out_ready low with a competing op offered; nothing may move
   task automatic hold(input int n, input logic [31:0] er, input logic [4:0] d);
      in_valid = 1'b1; in_op = OP_DIV_W; in_src1 = 32'h1234; in_src2 = 32'h0; in_dest = 5'd31;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_result", out_result, er);
         chk("hold_dest", 32'(out_dest), 32'(d));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_dv_req", 32'(dv_req), 32'd0);
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Writeback takes the result, optionally with a new op in the same cycle
   task automatic handshake(input bit nv, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] d);
      out_ready = 1'b1;
      in_valid = nv; in_op = op; in_src1 = a; in_src2 = b; in_dest = d;
      @(negedge clk);
      chk("hs_out_valid", 32'(out_valid), 32'd1);
      chk("hs_in_ready", 32'(in_ready), 32'd1);
      chk("hs_dv_req", 32'(dv_req), 32'd0);
      tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] d, input int stall);
      issue(op, a, b, d);
      wait_result(op, a, b, d);
      hold(stall, ref_result(op, a, b), d);
      handshake(1'b0, OP_DIV_W, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_dv_req", 32'(dv_req), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dv_signed", 32'(dv_signed), 32'd0);
      chk("rst_out_result", out_result, 32'h0);
      chk("rst_dv_x", dv_x, 32'h0);
      chk("rst_dv_y", dv_y, 32'h0);
      chk("rst_out_dest", 32'(out_dest), 32'd0);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   logic [1:0]  c_op, n_op;
   logic [31:0] c_a, c_b, n_a, n_b;
   logic [4:0]  c_d, n_d;

   initial begin
      reset = 1'b1; spur = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_op = 2'b00; in_src1 = 32'h0; in_src2 = 32'h0; in_dest = 5'd0;
      out_ready = 1'b0;
      #1;
      chk_reset_vals();
      tick();
      reset = 1'b0;
      tick();

      one(OP_DIV_W, 32'd100, -32'sd7, 5'd3, 0);
      one(OP_MOD_W, -32'sd100, 32'd7, 5'd12, 1);
      one(OP_MOD_WU, 32'hFFFF_FFFF, 32'd2, 5'd17, 0);
      one(OP_DIV_WU, 32'hFFFF_FFFF, 32'd2, 5'd18, 2);

      // Stalled writeback, then same-cycle handoff to a new op
      issue(OP_DIV_W, 32'd1000, 32'd9, 5'd5);
      wait_result(OP_DIV_W, 32'd1000, 32'd9, 5'd5);
      hold(5, ref_result(OP_DIV_W, 32'd1000, 32'd9), 5'd5);
      handshake(1'b1, OP_MOD_W, -32'sd1000, 32'd9, 5'd6);
      wait_result(OP_MOD_W, -32'sd1000, 32'd9, 5'd6);
      handshake(1'b0, OP_DIV_W, 32'h0, 32'h0, 5'd0);

      // A stray complete while idle must not produce a result
      spur = 1'b1;
      tick();
      spur = 1'b0;
      @(negedge clk);
      chk("spur_out_valid", 32'(out_valid), 32'd0);
      chk("spur_in_ready", 32'(in_ready), 32'd1);
      tick();

      // Flush at BUSY cycle 10, then a fresh op in the very next cycle
      issue(OP_DIV_WU, 32'd1000, 32'd3, 5'd7);
      repeat (9) tick();
      flush = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      chk("flush_dv_req", 32'(dv_req), 32'd1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      issue(OP_MOD_W, -32'sd12345, 32'd77, 5'd9);
      wait_result(OP_MOD_W, -32'sd12345, 32'd77, 5'd9);
      handshake(1'b0, OP_DIV_W, 32'h0, 32'h0, 5'd0);

      // Reset mid-BUSY
      issue(OP_DIV_W, 32'd5000, 32'd13, 5'd4);
      repeat (5) tick();
      reset = 1'b1;
      #1;
      chk_reset_vals();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      tick();

      // Divide by zero (fast path when enabled)
      one(OP_MOD_WU, 32'd5, 32'd0, 5'd8, 1);
      one(OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);

      // Random chained ops
      c_op = 2'($urandom); c_a = rand_operand(); c_b = rand_operand(); c_d = 5'($urandom);
      issue(c_op, c_a, c_b, c_d);
      for (int i = 0; i < 16; i++) begin
         wait_result(c_op, c_a, c_b, c_d);
         hold($urandom_range(0, 3), ref_result(c_op, c_a, c_b), c_d);
         n_op = 2'($urandom); n_a = rand_operand(); n_b = rand_operand(); n_d = 5'($urandom);
         handshake(1'b1, n_op, n_a, n_b, n_d);
         c_op = n_op; c_a = n_a; c_b = n_b; c_d = n_d;
      end
      wait_result(c_op, c_a, c_b, c_d);
      handshake(1'b0, OP_DIV_W, 32'h0, 32'h0, 5'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_issue.md
# div_issue

Divide-request controller in the EXE stage. It accepts DIV.W/MOD.W/DIV.WU/MOD.WU micro-ops from the pipeline over a valid/ready handshake and drives the iterative 32-bit divider's request interface: `div`, `div_signed`, `x`, `y` in; `q`, `r`, `complete` out. It holds the operands stable, waits for `complete`, selects quotient or remainder, buffers the result until writeback accepts it, and cancels cleanly on pipeline flush.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock, shared with the divider
- `reset`  in  1  asynchronous, active-high
- `in_valid`  in  1  micro-op present
- `in_ready`  out  1  block can accept a micro-op this cycle
- `in_op`  in  2  00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU
- `in_src1`  in  32  dividend
- `in_src2`  in  32  divisor
- `in_dest`  in  5  destination register
- `flush`  in  1  kill any in-flight or buffered op
- `out_valid`  out  1  result available
- `out_ready`  in  1  writeback consumes the result
- `out_result`  out  32  quotient or remainder
- `out_dest`  out  5  destination register of the result
- `dv_req`  out  1  to divider `div`; held high for the whole operation
- `dv_signed`  out  1  to divider `div_signed`
- `dv_x`  out  32  to divider `x`; registered
- `dv_y`  out  32  to divider `y`; registered
- `dv_complete`  in  1  from divider `complete`
- `dv_q`  in  32  from divider `q`
- `dv_r`  in  32  from divider `r`

## Operation
- States:
  - IDLE
  - BUSY: `dv_req`=1
  - DONE: `out_valid`=1
- Accept condition: `in_valid & in_ready & ~flush`.
- `in_ready` = (IDLE | (DONE & `out_ready`)) & ~`flush`.
- On accept:
  - Register `dv_x`=`in_src1`, `dv_y`=`in_src2`, `dv_signed`=~`in_op[1]`, a sel_r flag=`in_op[0]`, and `in_dest`.
  - Next state is BUSY.
- BUSY:
  - `dv_req`=1.
  - `dv_x`, `dv_y` and `dv_signed` are held constant, because the divider computes the sign correction combinationally from live inputs.
  - `dv_complete` is sampled only while `dv_req`=1. A high `dv_complete` while `dv_req`=0 is ignored.
  - On `dv_complete`: capture `out_result` = sel_r ? `dv_r` : `dv_q`. Next state is DONE.
- DONE:
  - `dv_req`=0. This is mandatory: it resets the divider's iteration counter so no spurious second run starts.
  - On `out_valid & out_ready`: go to BUSY if a new op is accepted in the same cycle, otherwise IDLE.
- Flush:
  - Highest priority, from any state. Next state is IDLE and `out_valid` is low next cycle.
  - `dv_req` drops next cycle; the divider counter resets because `div`=0.
- Reset values: state IDLE; `dv_req`, `out_valid`, `dv_signed` = 0; `out_result`, `dv_x`, `dv_y` = 0; `out_dest` = 0.
- Reset mid-operation: immediate return to reset values. The divider is reset by its own `resetn` through the parent.

## Timing
- Accept at cycle T (IDLE or DONE handshake cycle).
- `dv_req` is high from T+1. Divider count 0 at T+1, count 33 at T+34, where `complete`=1.
- Result is registered at the T+34 edge. `out_valid`=1 from T+35.
- Accept-to-`out_valid` latency is 35 cycles; throughput is one op per 35 cycles with `out_ready` tied high.
- `out_result` and `out_dest` are stable while `out_valid & ~out_ready`.
- `dv_req` is never high in two consecutive operations without an intervening low cycle. That low cycle is DONE or IDLE.

## Configuration
- Macro: `DIV_ZERO_FAST_EN`.
- Defined, divisor 0 on accept:
  - Bypass the divider: `dv_req` stays 0 and the next state is DONE directly.
  - `out_result` = sel_r ? `in_src1` : 32'hFFFF_FFFF, regardless of signedness.
  - `out_valid` at T+1.
- Undefined: divisor 0 runs the divider normally at 35-cycle latency and returns whatever the divider produces (unsigned: q=32'hFFFF_FFFF, r=`in_src1`).

## Structure
- Shared package `div_issue_pkg`:
  - Op encodings `OP_DIV_W`, `OP_MOD_W`, `OP_DIV_WU`, `OP_MOD_WU`.
  - State enum `{S_IDLE, S_BUSY, S_DONE}`.
  - `DIV_ITER_CYCLES`=34 and `DIV_ISSUE_LATENCY`=35 for the bench.
- No sub-module. The divider is instantiated beside this block by the EXE stage. Inverting `reset` to drive the divider's `resetn` is the parent's job.

## Test plan
- DIV.W 100 / -7 accepted at T -> `out_valid` rises at T+35, `out_result`=32'hFFFF_FFF2, `out_dest` matches, `dv_req` high T+1..T+34 only.
- MOD.W -100 % 7 -> 32'hFFFF_FFFE; MOD.WU 32'hFFFF_FFFF % 2 -> 1; DIV.WU same operands -> 32'h7FFF_FFFF.
- Hold `out_ready` low 5 cycles in DONE -> result and dest stable, `in_ready`=0. Then handshake with `in_valid` high -> new op accepted same cycle, `dv_req` low in that cycle, correct second result 35 cycles later.
- `flush` at BUSY cycle 10 -> `dv_req` low next cycle, no `out_valid`. Next op accepted the following cycle completes with the correct value at full 35-cycle latency.
- `reset` asserted mid-BUSY -> all outputs at reset values immediately, `in_ready`=1 after release.
- MOD.WU 5 / 0:
  - With `DIV_ZERO_FAST_EN`: `out_valid` at T+1, result 5, `dv_req` never high.
  - Without it: result 5 at T+35.
